stopwatch_core: RTL and testbench

Parametrised min:sec timekeeping core with up/down count direction, pause toggle, field adjust, countdown expiry and optional lap capture. It sits between the debouncers/clock divider and the seven-segment display driver. It replaces the fixed-width 00:00–59:59 counter and runs entirely on the system clock, qualified by single-cycle tick enables from the divider.

---
 rtl/stopwatch_core.sv | 210 +++++++++++++++++++++
 tb/tb_stopwatch_core.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_core.sv
// stopwatch_core
//   Parametrised min:sec timekeeping core. Counts up or down on 1 Hz
//   sec_tick enables, toggles run/pause on rising edges of the debounced
//   pause level, lets the user step either field on 2 Hz adj_tick enables,
//   and freezes at 00:00 with an expiry flag when a countdown runs out.
//   Runs on the system clock only; every output is a register.
//
//   Optional feature macro: STOPWATCH_LAP_EN
//     defined     - lap edge detector and lap capture registers are built
//     not defined - lap is ignored, lap_min/lap_sec/lap_valid tied to 0
//
// Parameters
//   MIN_W, SEC_W     field widths
//   MIN_MAX, SEC_MAX largest field values (must fit their widths)
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   sec_tick   1 Hz count enable pulse
//   adj_tick   2 Hz adjust enable pulse
//   sel        adjust field select (0 minutes, 1 seconds)
//   adj        adjust mode level
//   pause      pause level; each rising edge toggles run/pause
//   dir        0 count up, 1 count down
//   lap        lap level; rising edge captures / releases the lap value
//   minutes    current minutes
//   seconds    current seconds
//   running    run flag
//   adjusting  high while in adjust mode
//   expired    countdown reached 00:00
//   lap_min    captured minutes
//   lap_sec    captured seconds
//   lap_valid  lap registers hold a frozen value

module stopwatch_core #(
   parameter int MIN_W   = 6,
   parameter int SEC_W   = 6,
   parameter int MIN_MAX = 59,
   parameter int SEC_MAX = 59
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sec_tick,
   input  logic             adj_tick,
   input  logic             sel,
   input  logic             adj,
   input  logic             pause,
   input  logic             dir,
   input  logic             lap,
   output logic [MIN_W-1:0] minutes,
   output logic [SEC_W-1:0] seconds,
   output logic             running,
   output logic             adjusting,
   output logic             expired,
   output logic [MIN_W-1:0] lap_min,
   output logic [SEC_W-1:0] lap_sec,
   output logic             lap_valid
);

   typedef enum logic [1:0] {
      RUN,
      PAUSED,
      ADJUST,
      EXPIRED
   } state_t;

   localparam logic [MIN_W-1:0] MIN_TOP = MIN_W'(MIN_MAX);
   localparam logic [SEC_W-1:0] SEC_TOP = SEC_W'(SEC_MAX);
   localparam logic [MIN_W-1:0] MIN_ONE = MIN_W'(1);
   localparam logic [SEC_W-1:0] SEC_ONE = SEC_W'(1);

   state_t           state;
   state_t           state_nxt;
   logic [MIN_W-1:0] min_nxt;
   logic [SEC_W-1:0] sec_nxt;
   logic             run_nxt;
   logic             exp_nxt;
   logic             pause_q;
   logic             pause_edge;

   assign pause_edge = pause & ~pause_q;

   // ------------------------------------------------------------------
   // State register and datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         minutes   <= '0;
         seconds   <= '0;
         running   <= 1'b1;
         adjusting <= 1'b0;
         expired   <= 1'b0;
         pause_q   <= 1'b0;
      end else begin
         state     <= state_nxt;
         minutes   <= min_nxt;
         seconds   <= sec_nxt;
         running   <= run_nxt;
         adjusting <= (state_nxt == ADJUST);
         expired   <= exp_nxt;
         pause_q   <= pause;
      end
   end

   // ------------------------------------------------------------------
   // Next-state / next-value logic
   // Priority: adj > expiry hold > pause edge > sec_tick.
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      min_nxt   = minutes;
      sec_nxt   = seconds;
      run_nxt   = running;
      exp_nxt   = expired;

      if (adj) begin
         // Adjust mode: a pause edge only flips the flag remembered for exit.
         state_nxt = ADJUST;
         exp_nxt   = 1'b0;
         if (pause_edge) begin
            run_nxt = ~running;
         end
         if (adj_tick) begin
            if (sel) begin
               sec_nxt = (seconds == SEC_TOP) ? '0 : seconds + SEC_ONE;
            end else begin
               min_nxt = (minutes == MIN_TOP) ? '0 : minutes + MIN_ONE;
            end
         end
      end else begin
         case (state)
            ADJUST: begin
               // Leaving adjust: an edge in this same cycle still counts as
               // an adjust-mode toggle, and the exit state follows the result.
               if (pause_edge) begin
                  run_nxt = ~running;
               end
               state_nxt = run_nxt ? RUN : PAUSED;
            end
            EXPIRED: begin
               state_nxt = EXPIRED;
            end
            default: begin
               if (pause_edge) begin
                  run_nxt   = ~running;
                  state_nxt = running ? PAUSED : RUN;
               end
               // The tick is qualified by the pre-toggle run flag.
               if (sec_tick && running) begin
                  if (!dir) begin
                     if (seconds != SEC_TOP) begin
                        sec_nxt = seconds + SEC_ONE;
                     end else begin
                        sec_nxt = '0;
                        min_nxt = (minutes == MIN_TOP) ? '0 : minutes + MIN_ONE;
                     end
                  end else if (seconds != '0) begin
                     sec_nxt = seconds - SEC_ONE;
                  end else if (minutes != '0) begin
                     sec_nxt = SEC_TOP;
                     min_nxt = minutes - MIN_ONE;
                  end else begin
                     // Already at 00:00: expiry overrides any same-cycle toggle.
                     exp_nxt   = 1'b1;
                     run_nxt   = 1'b0;
                     state_nxt = EXPIRED;
                  end
               end
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Lap capture
   // ------------------------------------------------------------------
`ifdef STOPWATCH_LAP_EN
   logic lap_q;

   // Captures the registered (pre-tick) time of the edge cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         lap_q     <= 1'b0;
         lap_min   <= '0;
         lap_sec   <= '0;
         lap_valid <= 1'b0;
      end else begin
         lap_q <= lap;
         if (lap && !lap_q) begin
            if (!lap_valid) begin
               lap_min   <= minutes;
               lap_sec   <= seconds;
               lap_valid <= 1'b1;
            end else begin
               lap_valid <= 1'b0;
            end
         end
      end
   end
`else
   logic unused_lap;

   assign unused_lap = lap;
   assign lap_min    = '0;
   assign lap_sec    = '0;
   assign lap_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core
//   Self-checking bench for stopwatch_core. A time-in-seconds reference
//   model tracks the expected display, flags and lap value; directed
//   scenario tasks check the documented behaviours and a randomized run
//   compares every output against the model each cycle.

module tb_stopwatch_core;

   localparam int MW    = 6;
   localparam int SW    = 6;
   localparam int MMAX  = 59;
   localparam int SMAX  = 59;
   localparam int NSEC  = SMAX + 1;
   localparam int NTOT  = (MMAX + 1) * NSEC;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          sec_tick = 1'b0;
   logic          adj_tick = 1'b0;
   logic          sel = 1'b0;
   logic          adj = 1'b0;
   logic          pause = 1'b0;
   logic          dir = 1'b0;
   logic          lap = 1'b0;
   logic [MW-1:0] minutes;
   logic [SW-1:0] seconds;
   logic          running;
   logic          adjusting;
   logic          expired;
   logic [MW-1:0] lap_min;
   logic [SW-1:0] lap_sec;
   logic          lap_valid;

   int n_chk  = 0;
   int n_fail = 0;

   // reference model: time held as total seconds
   int m_t   = 0;
   bit m_run = 1'b1;
   bit m_adj = 1'b0;
   bit m_exp = 1'b0;
   bit m_pq  = 1'b0;
   bit m_lq  = 1'b0;
   int m_lt  = 0;
   bit m_lv  = 1'b0;

   stopwatch_core #(
      .MIN_W  (MW),
      .SEC_W  (SW),
      .MIN_MAX(MMAX),
      .SEC_MAX(SMAX)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .sec_tick (sec_tick),
      .adj_tick (adj_tick),
      .sel      (sel),
      .adj      (adj),
      .pause    (pause),
      .dir      (dir),
      .lap      (lap),
      .minutes  (minutes),
      .seconds  (seconds),
      .running  (running),
      .adjusting(adjusting),
      .expired  (expired),
      .lap_min  (lap_min),
      .lap_sec  (lap_sec),
      .lap_valid(lap_valid)
   );

   always #5 clk = ~clk;

   task automatic model_update();
      bit pe;
      bit le;
      bit old_run;
      int s;
      int m;
      if (rst) begin
         m_t = 0; m_run = 1'b1; m_adj = 1'b0; m_exp = 1'b0;
         m_pq = 1'b0; m_lq = 1'b0; m_lt = 0; m_lv = 1'b0;
      end else begin
         pe = pause && !m_pq;
         le = lap && !m_lq;
         m_pq = pause;
         m_lq = lap;
         if (le) begin
            if (!m_lv) begin m_lt = m_t; m_lv = 1'b1; end
            else m_lv = 1'b0;
         end
         if (adj) begin
            m_adj = 1'b1;
            m_exp = 1'b0;
            if (pe) m_run = !m_run;
            if (adj_tick) begin
               s = m_t % NSEC;
               m = m_t / NSEC;
               if (sel) s = (s + 1) % NSEC;
               else     m = (m + 1) % (MMAX + 1);
               m_t = m * NSEC + s;
            end
         end else if (m_adj) begin
            if (pe) m_run = !m_run;
            m_adj = 1'b0;
         end else if (!m_exp) begin
            old_run = m_run;
            if (pe) m_run = !m_run;
            if (sec_tick && old_run) begin
               if (!dir)           m_t = (m_t + 1) % NTOT;
               else if (m_t == 0) begin m_exp = 1'b1; m_run = 1'b0; end
               else                m_t = m_t - 1;
            end
         end
      end
   endtask

   // one clock: inputs are sampled at the edge, outputs read 1 time unit later
   task automatic cycle();
      @(posedge clk);
      model_update();
      #1;
      rst      = 1'b0;
      sec_tick = 1'b0;
      adj_tick = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         sec_tick = 1'b1;
         cycle();
      end
   endtask

   // steps the fields to m:s through adjust mode; leaves adj high if keep
   task automatic preset(input int m, input int s, input bit keep);
      int guard;
      adj = 1'b1;
      sel = 1'b0;
      cycle();
      guard = 0;
      while ((m_t / NSEC) != m && guard < 200) begin
         adj_tick = 1'b1;
         cycle();
         guard++;
      end
      sel = 1'b1;
      guard = 0;
      while ((m_t % NSEC) != s && guard < 200) begin
         adj_tick = 1'b1;
         sec_tick = 1'b1;
         cycle();
         guard++;
      end
      if (!keep) begin
         adj = 1'b0;
         cycle();
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_chk++;
      if ({minutes, seconds, running, adjusting, expired} !== {6'd0, 6'd0, 1'b1, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_state: got %0d:%0d run=%0b adj=%0b exp=%0b, want 0:0 run=1 adj=0 exp=0",
                  minutes, seconds, running, adjusting, expired);
      end
      n_chk++;
      if ({lap_min, lap_sec, lap_valid} !== 13'd0) begin
         n_fail++;
         $display("FAIL reset_lap: got %0d:%0d valid=%0b, want 0:0 valid=0", lap_min, lap_sec, lap_valid);
      end
   endtask

   task automatic test_up_count();
      do_reset();
      dir = 1'b0;
      ticks(60);
      n_chk++;
      if ({minutes, seconds} !== {6'd1, 6'd0}) begin
         n_fail++;
         $display("FAIL up_60_ticks: got %0d:%0d, want 1:0", minutes, seconds);
      end
      preset(59, 58, 1'b0);
      ticks(1);
      n_chk++;
      if ({minutes, seconds} !== {6'd59, 6'd59}) begin
         n_fail++;
         $display("FAIL up_to_max: got %0d:%0d, want 59:59", minutes, seconds);
      end
      ticks(1);
      n_chk++;
      if ({minutes, seconds, expired, running} !== {6'd0, 6'd0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL up_full_wrap: got %0d:%0d exp=%0b run=%0b, want 0:0 exp=0 run=1",
                  minutes, seconds, expired, running);
      end
   endtask

   task automatic test_down_expire();
      do_reset();
      preset(0, 2, 1'b0);
      dir = 1'b1;
      ticks(1);
      n_chk++;
      if ({minutes, seconds, expired} !== {6'd0, 6'd1, 1'b0}) begin
         n_fail++;
         $display("FAIL down_0001: got %0d:%0d exp=%0b, want 0:1 exp=0", minutes, seconds, expired);
      end
      ticks(1);
      n_chk++;
      if ({minutes, seconds, expired, running} !== {6'd0, 6'd0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL down_0000_no_exp: got %0d:%0d exp=%0b run=%0b, want 0:0 exp=0 run=1",
                  minutes, seconds, expired, running);
      end
      ticks(1);
      n_chk++;
      if ({minutes, seconds, expired, running} !== {6'd0, 6'd0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL down_expire: got %0d:%0d exp=%0b run=%0b, want 0:0 exp=1 run=0",
                  minutes, seconds, expired, running);
      end
      dir = 1'b0;
      ticks(3);
      pause = 1'b1;
      cycle();
      pause = 1'b0;
      n_chk++;
      if ({minutes, seconds, expired, running} !== {6'd0, 6'd0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL expired_hold: got %0d:%0d exp=%0b run=%0b, want 0:0 exp=1 run=0",
                  minutes, seconds, expired, running);
      end
      adj = 1'b1;
      cycle();
      n_chk++;
      if ({expired, adjusting} !== 2'b01) begin
         n_fail++;
         $display("FAIL adj_clears_exp: got exp=%0b adjusting=%0b, want exp=0 adjusting=1", expired, adjusting);
      end
      adj = 1'b0;
      cycle();
      n_chk++;
      if ({running, adjusting} !== 2'b00) begin
         n_fail++;
         $display("FAIL exit_to_paused: got run=%0b adjusting=%0b, want run=0 adjusting=0", running, adjusting);
      end
   endtask

   task automatic test_pause();
      do_reset();
      dir = 1'b0;
      ticks(10);
      pause = 1'b1;
      cycle();
      pause = 1'b0;
      ticks(5);
      n_chk++;
      if ({minutes, seconds, running} !== {6'd0, 6'd10, 1'b0}) begin
         n_fail++;
         $display("FAIL paused_hold: got %0d:%0d run=%0b, want 0:10 run=0", minutes, seconds, running);
      end
      pause = 1'b1;
      cycle();
      pause = 1'b0;
      ticks(1);
      n_chk++;
      if ({minutes, seconds, running} !== {6'd0, 6'd11, 1'b1}) begin
         n_fail++;
         $display("FAIL resume: got %0d:%0d run=%0b, want 0:11 run=1", minutes, seconds, running);
      end
      pause = 1'b1;
      ticks(1);
      pause = 1'b0;
      n_chk++;
      if ({minutes, seconds, running} !== {6'd0, 6'd12, 1'b0}) begin
         n_fail++;
         $display("FAIL pause_with_tick: got %0d:%0d run=%0b, want 0:12 run=0", minutes, seconds, running);
      end
      ticks(2);
      n_chk++;
      if ({minutes, seconds} !== {6'd0, 6'd12}) begin
         n_fail++;
         $display("FAIL paused_after_tick: got %0d:%0d, want 0:12", minutes, seconds);
      end
   endtask

   task automatic test_adjust();
      logic [SW-1:0] want_s [3];
      want_s[0] = 6'd59;
      want_s[1] = 6'd0;
      want_s[2] = 6'd1;
      do_reset();
      preset(0, 58, 1'b1);
      dir = 1'b1;
      for (int i = 0; i < 3; i++) begin
         adj_tick = 1'b1;
         sec_tick = 1'b1;
         cycle();
         n_chk++;
         if ({minutes, seconds, adjusting} !== {6'd0, want_s[i], 1'b1}) begin
            n_fail++;
            $display("FAIL adj_sec_step%0d: got %0d:%0d adjusting=%0b, want 0:%0d adjusting=1",
                     i, minutes, seconds, adjusting, want_s[i]);
         end
      end
      sel = 1'b0;
      for (int i = 0; i < 59; i++) begin
         adj_tick = 1'b1;
         cycle();
      end
      n_chk++;
      if ({minutes, seconds} !== {6'd59, 6'd1}) begin
         n_fail++;
         $display("FAIL adj_min_59: got %0d:%0d, want 59:1", minutes, seconds);
      end
      adj_tick = 1'b1;
      sec_tick = 1'b1;
      cycle();
      n_chk++;
      if ({minutes, seconds} !== {6'd0, 6'd1}) begin
         n_fail++;
         $display("FAIL adj_min_wrap: got %0d:%0d, want 0:1", minutes, seconds);
      end
      adj = 1'b0;
      dir = 1'b0;
      cycle();
      n_chk++;
      if ({adjusting, running} !== 2'b01) begin
         n_fail++;
         $display("FAIL adj_exit_run: got adjusting=%0b run=%0b, want adjusting=0 run=1", adjusting, running);
      end
   endtask

   task automatic test_lap();
      do_reset();
      dir = 1'b0;
      ticks(5);
      lap = 1'b1;
      ticks(1);
      lap = 1'b0;
      n_chk++;
      if ({minutes, seconds} !== {6'd0, 6'd6}) begin
         n_fail++;
         $display("FAIL lap_count_continues: got %0d:%0d, want 0:6", minutes, seconds);
      end
`ifdef STOPWATCH_LAP_EN
      n_chk++;
      if ({lap_min, lap_sec, lap_valid} !== {6'd0, 6'd5, 1'b1}) begin
         n_fail++;
         $display("FAIL lap_capture: got %0d:%0d valid=%0b, want 0:5 valid=1", lap_min, lap_sec, lap_valid);
      end
      ticks(1);
      lap = 1'b1;
      cycle();
      lap = 1'b0;
      n_chk++;
      if ({lap_min, lap_sec, lap_valid} !== {6'd0, 6'd5, 1'b0}) begin
         n_fail++;
         $display("FAIL lap_release: got %0d:%0d valid=%0b, want 0:5 valid=0", lap_min, lap_sec, lap_valid);
      end
`else
      ticks(1);
      lap = 1'b1;
      cycle();
      lap = 1'b0;
      n_chk++;
      if ({lap_min, lap_sec, lap_valid} !== 13'd0) begin
         n_fail++;
         $display("FAIL lap_disabled: got %0d:%0d valid=%0b, want 0:0 valid=0", lap_min, lap_sec, lap_valid);
      end
`endif
   endtask

   task automatic test_reset_mid_adjust();
      do_reset();
      preset(12, 34, 1'b1);
      n_chk++;
      if ({minutes, seconds, adjusting} !== {6'd12, 6'd34, 1'b1}) begin
         n_fail++;
         $display("FAIL preset_1234: got %0d:%0d adjusting=%0b, want 12:34 adjusting=1", minutes, seconds, adjusting);
      end
      adj = 1'b0;
      rst = 1'b1;
      cycle();
      n_chk++;
      if ({minutes, seconds, running, adjusting, expired} !== {6'd0, 6'd0, 1'b1, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_mid_adjust: got %0d:%0d run=%0b adjusting=%0b exp=%0b, want 0:0 run=1 adjusting=0 exp=0",
                  minutes, seconds, running, adjusting, expired);
      end
   endtask

   task automatic test_random();
      logic [MW-1:0] em;
      logic [SW-1:0] es;
      logic [MW-1:0] elm;
      logic [SW-1:0] els;
      logic          elv;
      int            errs;
      do_reset();
      errs = 0;
      for (int i = 0; i < 4000; i++) begin
         rst      = ($urandom_range(0, 499) == 0);
         sec_tick = ($urandom_range(0, 2) == 0);
         adj_tick = ($urandom_range(0, 3) == 0);
         sel      = $urandom_range(0, 1) != 0;
         if ($urandom_range(0, 39) == 0) adj   = ~adj;
         if ($urandom_range(0, 7)  == 0) pause = ~pause;
         if ($urandom_range(0, 29) == 0) dir   = ~dir;
         if ($urandom_range(0, 9)  == 0) lap   = ~lap;
         cycle();
         em = MW'(m_t / NSEC);
         es = SW'(m_t % NSEC);
`ifdef STOPWATCH_LAP_EN
         elm = MW'(m_lt / NSEC);
         els = SW'(m_lt % NSEC);
         elv = m_lv;
`else
         elm = '0;
         els = '0;
         elv = 1'b0;
`endif
         n_chk++;
         if ({minutes, seconds} !== {em, es}) begin
            n_fail++;
            if (errs++ < 10) $display("FAIL rand_time cyc %0d: got %0d:%0d, want %0d:%0d", i, minutes, seconds, em, es);
         end
         n_chk++;
         if ({running, adjusting, expired} !== {m_run, m_adj, m_exp}) begin
            n_fail++;
            if (errs++ < 10) $display("FAIL rand_flags cyc %0d: got run/adj/exp=%0b%0b%0b, want %0b%0b%0b",
                                      i, running, adjusting, expired, m_run, m_adj, m_exp);
         end
         n_chk++;
         if ({lap_min, lap_sec, lap_valid} !== {elm, els, elv}) begin
            n_fail++;
            if (errs++ < 10) $display("FAIL rand_lap cyc %0d: got %0d:%0d valid=%0b, want %0d:%0d valid=%0b",
                                      i, lap_min, lap_sec, lap_valid, elm, els, elv);
         end
      end
      adj   = 1'b0;
      pause = 1'b0;
      lap   = 1'b0;
      dir   = 1'b0;
   endtask

   initial begin
      #2;
      test_reset();
      test_up_count();
      test_down_expire();
      test_pause();
      test_adjust();
      test_lap();
      test_reset_mid_adjust();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
